// File: rtl/seq_det_sched_if.sv
// Word handshake and scan-result signals shared by the 1101 scan scheduler and its driver.
interface seq_det_sched_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_first;
    logic             in_ready;
    logic             busy;
    logic             hit;
    logic             done;
    logic [CW-1:0]    hit_count;

    modport master (
        output in_valid, in_data, in_first,
        input  in_ready, busy, hit, done, hit_count
    );

    modport slave (
        input  in_valid, in_data, in_first,
        output in_ready, busy, hit, done, hit_count
    );
endinterface

// File: rtl/seq_det_sched.sv
// Accepts one word at a time, serialises it MSB first into an overlapping Mealy 1101 detector
// and reports per-word detection count; detector history carries across words unless in_first.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for in_valid
//   SHIFT | one bit per cycle into the detector, bit index counts down to 0
//   DONE  | one-cycle done pulse, hit_count final
module seq_det_sched #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    seq_det_sched_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

    state_t           state, state_next;
    det_t             det, det_next;
    logic             det_hit;
    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]    bit_idx;
    logic             hit_q;
    logic [CW-1:0]    cnt;
    logic             cur_bit;

    assign cur_bit = shreg[WIDTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = SHIFT;
            SHIFT:   if (bit_idx == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Overlapping 1101: after a match the trailing 1 already counts as a prefix.
    always_comb begin
        det_next = det;
        det_hit  = 1'b0;
        case (det)
            S0: det_next = cur_bit ? S1 : S0;
            S1: det_next = cur_bit ? S2 : S0;
            S2: det_next = cur_bit ? S2 : S3;
            S3: begin
                if (cur_bit) begin
                    det_next = S1;
                    det_hit  = 1'b1;
                end else begin
                    det_next = S0;
                end
            end
            default: det_next = S0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            bit_idx <= '0;
            det     <= S0;
            hit_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            hit_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg   <= bus.in_data;
                        bit_idx <= IW'(WIDTH - 1);
                        cnt     <= '0;
                        if (bus.in_first) det <= S0;
                    end
                end
                SHIFT: begin
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    bit_idx <= bit_idx - IW'(1);
                    det     <= det_next;
                    hit_q   <= det_hit;
                    if (det_hit) cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == SHIFT);
    assign bus.done      = (state == DONE);
    assign bus.hit       = hit_q;
    assign bus.hit_count = cnt;
endmodule

// File: tb/tb_seq_det_sched.sv
// Self-checking bench for seq_det_sched: directed word table, mid-scan reset, then random words
// checked against a sliding-window reference of the bit stream.
module tb_seq_det_sched;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk;
    logic reset;

    seq_det_sched_if #(.WIDTH(W), .CW(CW)) bus ();

    seq_det_sched #(.WIDTH(W), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference: last four bits seen since history was cleared; a match is the window equal to 1101.
    logic [3:0] win;
    int         wlen;

    typedef struct {
        logic [W-1:0] data;
        logic         first;
        logic [W-1:0] exp_mask;
        int           exp_cnt;
        bit           noisy;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic model_word(input logic [W-1:0] d, input logic f,
                              output logic [W-1:0] m, output int c);
        if (f) wlen = 0;
        m = '0;
        c = 0;
        for (int p = 0; p < W; p++) begin
            win = {win[2:0], d[W-1-p]};
            wlen++;
            if (wlen >= 4 && win == 4'b1101) begin
                m[W-1-p] = 1'b1;
                c++;
            end
        end
    endtask

    task automatic drive_noise(input bit noisy);
        if (noisy) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'($urandom);
            bus.in_first = 1'($urandom);
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the cycle after DONE.
    task automatic run_word(input string name, input logic [W-1:0] d, input logic f,
                            input logic [W-1:0] exp_mask, input int exp_cnt, input bit noisy);
        logic [W-1:0] obs;
        bit           ctrl_ok;
        obs     = '0;
        ctrl_ok = 1'b1;
        chk({name, ".ready_before"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_first = f;
        @(negedge clk);
        for (int j = 0; j < W; j++) begin
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) ctrl_ok = 1'b0;
            if (j == 0) begin
                if (bus.hit !== 1'b0) ctrl_ok = 1'b0;
            end else begin
                obs[W-j] = bus.hit;
            end
            drive_noise(noisy);
            @(negedge clk);
        end
        chk({name, ".shift_ctrl"}, 32'(ctrl_ok), 32'd1);
        obs[0] = bus.hit;
        chk({name, ".done"}, {29'd0, bus.done, bus.busy, bus.in_ready}, 32'b100);
        chk({name, ".hit_mask"}, 32'(obs), 32'(exp_mask));
        chk({name, ".count"}, 32'(bus.hit_count), 32'(exp_cnt));
        drive_noise(noisy);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({name, ".after"}, {28'd0, bus.in_ready, bus.done, bus.hit_count == CW'(exp_cnt), bus.busy},
            32'b1010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] m;
        int           c;
        bit           seen_done;

        tbl[0] = '{8'b1101_1010, 1'b1, 8'b0001_0010, 2, 1'b1};
        tbl[1] = '{8'b0000_0110, 1'b1, 8'b0000_0000, 0, 1'b0};
        tbl[2] = '{8'b1000_0000, 1'b0, 8'b1000_0000, 1, 1'b0};
        tbl[3] = '{8'b1000_0000, 1'b1, 8'b0000_0000, 0, 1'b0};
        tbl[4] = '{8'hFF,        1'b1, 8'b0000_0000, 0, 1'b0};
        tbl[5] = '{8'h00,        1'b1, 8'b0000_0000, 0, 1'b0};
        tbl[6] = '{8'b1101_1101, 1'b1, 8'b0001_0001, 2, 1'b0};

        win  = '0;
        wlen = 0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_first = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hD0;
        @(negedge clk);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.hit", 32'(bus.hit), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.hit_count", 32'(bus.hit_count), 32'd0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            model_word(tbl[i].data, tbl[i].first, m, c);
            run_word($sformatf("tbl%0d", i), tbl[i].data, tbl[i].first,
                     tbl[i].exp_mask, tbl[i].exp_cnt, tbl[i].noisy);
        end

        // Reset in the third SHIFT cycle abandons the word and clears detector history.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'b1101_0000;
        bus.in_first = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst.busy_before", 32'(bus.busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("midrst.now", {28'd0, bus.in_ready, bus.busy, bus.done, bus.hit}, 32'b1000);
        chk("midrst.hit_count", 32'(bus.hit_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wlen = 0;
        seen_done = 1'b0;
        for (int j = 0; j < W + 2; j++) begin
            if (bus.done === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        chk("midrst.no_done", 32'(seen_done), 32'd0);
        model_word(8'b0100_0000, 1'b0, m, c);
        run_word("postrst", 8'b0100_0000, 1'b0, 8'b0000_0000, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] d;
            logic         f;
            bit           nz;
            d  = W'($urandom);
            f  = ($urandom_range(0, 3) == 0);
            nz = 1'($urandom);
            if (i % 5 == 0) d = {4'b1101, d[3:0]};
            model_word(d, f, m, c);
            run_word($sformatf("rnd%0d", i), d, f, m, c, nz);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
